// File: rtl/siso_llr_rev_buffer.sv
// Frame buffer: writes one LLR frame to an external RAM and replays it reversed.
// Optional overflow flag is built when LLR_BUF_OVF_CHECK_EN is defined.
module siso_llr_rev_buffer #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              ram_we,
  output logic [AW-1:0]     ram_wr_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic [AW-1:0]     ram_rd_addr,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic [AW:0]       frame_len,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DRAIN} state_e;

  localparam logic [AW:0] FULL = DEPTH[AW:0];

  state_e            state_q;
  logic [AW:0]       wr_cnt_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       frame_len_q;
  logic              ram_we_q;
  logic [AW-1:0]     ram_wr_addr_q;
  logic [DWIDTH-1:0] ram_din_q;
  logic              rd_done_q;
  logic              rd_vld_q;
  logic              rd_last_q;
  logic [DWIDTH-1:0] sk0_data_q;
  logic [DWIDTH-1:0] sk1_data_q;
  logic              sk0_last_q;
  logic              sk1_last_q;
  logic [1:0]        sk_cnt_q;

  logic        s_hs;
  logic        m_hs;
  logic        full;
  logic        issue;
  logic [1:0]  pend;
  logic [AW:0] fl_next;

  assign s_axis_tready = (state_q == IDLE) || (state_q == LOAD);
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign m_axis_tvalid = (sk_cnt_q != 2'd0);
  assign m_axis_tdata  = sk0_data_q;
  assign m_axis_tlast  = sk0_last_q & m_axis_tvalid;
  assign m_hs          = m_axis_tvalid & m_axis_tready;
  assign full          = (wr_cnt_q == FULL);
  assign fl_next       = full ? FULL : wr_cnt_q + 1'b1;

  assign ram_we      = ram_we_q;
  assign ram_wr_addr = ram_wr_addr_q;
  assign ram_din     = ram_din_q;
  // outside DRAIN the read port is parked away from the write address
  assign ram_rd_addr = (state_q == DRAIN) ? rd_ptr_q : ~ram_wr_addr_q;
  assign frame_len   = frame_len_q;
  assign busy        = (state_q != IDLE);

  // occupancy after this cycle's pop, counting the read already in flight
  always_comb begin
    pend  = sk_cnt_q - {1'b0, m_hs} + {1'b0, rd_vld_q};
    issue = (state_q == DRAIN) && !rd_done_q && (pend < 2'd2);
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_cnt_q      <= '0;
      rd_ptr_q      <= '0;
      frame_len_q   <= '0;
      ram_we_q      <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_din_q     <= '0;
      rd_done_q     <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_last_q     <= 1'b0;
      sk0_data_q    <= '0;
      sk1_data_q    <= '0;
      sk0_last_q    <= 1'b0;
      sk1_last_q    <= 1'b0;
      sk_cnt_q      <= 2'd0;
    end else begin
      ram_we_q <= 1'b0;
      unique case (state_q)
        IDLE, LOAD: begin
          if (s_hs) begin
            if (!full) begin
              ram_we_q      <= 1'b1;
              ram_wr_addr_q <= wr_cnt_q[AW-1:0];
              ram_din_q     <= s_axis_tdata;
              wr_cnt_q      <= wr_cnt_q + 1'b1;
            end
            if (s_axis_tlast) begin
              state_q     <= SETTLE;
              frame_len_q <= fl_next;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        SETTLE: begin
          state_q   <= DRAIN;
          rd_ptr_q  <= frame_len_q[AW-1:0] - 1'b1;
          rd_done_q <= 1'b0;
        end
        DRAIN: begin
          if (issue) begin
            if (rd_ptr_q == '0) rd_done_q <= 1'b1;
            else                rd_ptr_q  <= rd_ptr_q - 1'b1;
          end
          if (m_hs && m_axis_tlast) begin
            state_q     <= IDLE;
            wr_cnt_q    <= '0;
            rd_ptr_q    <= '0;
            frame_len_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase

      rd_vld_q  <= issue;
      rd_last_q <= issue && (rd_ptr_q == '0);

      unique case ({rd_vld_q, m_hs})
        2'b10: begin
          if (sk_cnt_q == 2'd0) begin
            sk0_data_q <= ram_dout;
            sk0_last_q <= rd_last_q;
          end else begin
            sk1_data_q <= ram_dout;
            sk1_last_q <= rd_last_q;
          end
          sk_cnt_q <= sk_cnt_q + 1'b1;
        end
        2'b01: begin
          sk0_data_q <= sk1_data_q;
          sk0_last_q <= sk1_last_q;
          sk_cnt_q   <= sk_cnt_q - 1'b1;
        end
        2'b11: begin
          if (sk_cnt_q == 2'd1) begin
            sk0_data_q <= ram_dout;
            sk0_last_q <= rd_last_q;
          end else begin
            sk0_data_q <= sk1_data_q;
            sk0_last_q <= sk1_last_q;
            sk1_data_q <= ram_dout;
            sk1_last_q <= rd_last_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LLR_BUF_OVF_CHECK_EN
  logic ovf_q;

  // sticky until the first beat of the next frame
  always_ff @(posedge aclk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (s_hs) begin
      if (state_q == IDLE) ovf_q <= 1'b0;
      else if (full)       ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_siso_llr_rev_buffer.sv
// Bench for siso_llr_rev_buffer: queue-based reverse-frame model plus directed cases.
module tb_siso_llr_rev_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef LLR_BUF_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          ram_we;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_din;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_dout = '0;
  logic [AW:0]   frame_len;
  logic          busy;
  logic          ovf;

  always #5 aclk = ~aclk;

  siso_llr_rev_buffer #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_din(ram_din),
    .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout),
    .frame_len(frame_len), .busy(busy), .ovf(ovf)
  );

  // simple dual-port RAM, registered read, read-before-write
  logic [DW-1:0] mem [DEPTH];
  always @(posedge aclk) begin
    if (ram_we) mem[ram_wr_addr] <= ram_din;
    ram_dout <= mem[ram_rd_addr];
  end

  bit rand_rdy = 1'b0;
  always @(posedge aclk) begin
    #1;
    m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] frm[$];
  int  fl_m = 0;
  int  out_cnt = 0;
  bit  ovf_m = 1'b0;

  // compare process: every output handshake against the reversed-frame queue
  bit            stall = 1'b0;
  logic [DW-1:0] pdata = '0;
  logic          plast = 1'b0;
  always @(negedge aclk) begin
    if (reset) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", 32'(m_axis_tvalid), 32'(1));
        chk("hold_data", 32'(m_axis_tdata), 32'(pdata));
        chk("hold_last", 32'(m_axis_tlast), 32'(plast));
      end
      if (m_axis_tvalid) chk("frame_len", 32'(frame_len), 32'(fl_m));
      if (ram_we)
        chk("addr_clash", 32'(ram_wr_addr == ram_rd_addr), 32'(0));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'(1), 32'(0));
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          chk("m_tdata", 32'(m_axis_tdata), 32'(e));
          chk("m_tlast", 32'(m_axis_tlast), 32'(exp_q.size() == 0));
        end
        out_cnt++;
      end
      stall = m_axis_tvalid && !m_axis_tready;
      pdata = m_axis_tdata;
      plast = m_axis_tlast;
    end
  end

  task automatic send_frame(input int n, input logic [DW-1:0] first);
    int beats;
    frm.delete();
    beats = 0;
    for (int i = 0; i < n; i++) begin
      int w;
      @(negedge aclk);
      s_axis_tdata  = 16'(first + 16'(i));
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == n - 1);
      if (i >= DEPTH) chk("tready_beyond", 32'(s_axis_tready), 32'(1));
      w = 0;
      while (!s_axis_tready && w < 50) begin
        @(negedge aclk);
        w++;
      end
      chk("s_tready_wait", 32'(s_axis_tready), 32'(1));
      chk("ovf_flag", 32'(ovf), 32'(OVF_EN & ovf_m));
      @(posedge aclk);
      if (i == 0) ovf_m = 1'b0;
      if (beats < DEPTH) frm.push_back(s_axis_tdata);
      else ovf_m = 1'b1;
      beats++;
    end
    fl_m = (n < DEPTH) ? n : DEPTH;
    out_cnt = 0;
    exp_q.delete();
    for (int j = frm.size() - 1; j >= 0; j--) exp_q.push_back(frm[j]);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!m_axis_tvalid && lat < 40) begin
      @(negedge aclk);
      lat++;
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 1000) begin
      @(negedge aclk);
      w++;
    end
    chk("idle_timeout", 32'(busy), 32'(0));
  endtask

  initial begin
    int lat;
    int cnt;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_flen", 32'(frame_len), 32'(0));
    chk("rst_we", 32'(ram_we), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    chk("rst_tready", 32'(s_axis_tready), 32'(1));
    reset = 1'b0;

    // T1: 1..8 reversed, fixed latency, full rate
    send_frame(8, 16'd1);
    wait_valid(lat);
    chk("t1_latency", 32'(lat), 32'(3));
    chk("t1_first", 32'(m_axis_tdata), 32'(8));
    chk("t1_flen", 32'(frame_len), 32'(8));
    cnt = 0;
    while (m_axis_tvalid && cnt < 50) begin
      cnt++;
      @(negedge aclk);
    end
    chk("t1_run", 32'(cnt), 32'(8));
    chk("t1_busy", 32'(busy), 32'(0));

    // T2: single-word frame
    send_frame(1, 16'h00AB);
    chk("t2_settle_rdy", 32'(s_axis_tready), 32'(0));
    chk("t2_settle_busy", 32'(busy), 32'(1));
    wait_valid(lat);
    chk("t2_data", 32'(m_axis_tdata), 32'(16'h00AB));
    chk("t2_last", 32'(m_axis_tlast), 32'(1));
    chk("t2_drain_rdy", 32'(s_axis_tready), 32'(0));
    @(negedge aclk);
    chk("t2_busy", 32'(busy), 32'(0));
    chk("t2_rdy", 32'(s_axis_tready), 32'(1));

    // T3: full-depth frame under random backpressure
    rand_rdy = 1'b1;
    send_frame(16, 16'd1);
    wait_idle();
    chk("t3_left", 32'(exp_q.size()), 32'(0));
    chk("t3_count", 32'(out_cnt), 32'(16));
    rand_rdy = 1'b0;
    @(negedge aclk);

    // T4: 18 beats into 16 words
    send_frame(18, 16'd1);
    chk("t4_flen", 32'(frame_len), 32'(16));
    chk("t4_ovf", 32'(ovf), 32'(OVF_EN));
    wait_valid(lat);
    chk("t4_first", 32'(m_axis_tdata), 32'(16));
    wait_idle();
    chk("t4_left", 32'(exp_q.size()), 32'(0));
    chk("t4_count", 32'(out_cnt), 32'(16));
    chk("t4_ovf_sticky", 32'(ovf), 32'(OVF_EN));

    // T5: reset mid-drain, then a clean frame
    send_frame(8, 16'd1);
    cnt = 0;
    while (out_cnt < 3 && cnt < 100) begin
      @(negedge aclk);
      #1;
      cnt++;
    end
    chk("t5_outs", 32'(out_cnt), 32'(3));
    reset = 1'b1;
    exp_q.delete();
    ovf_m = 1'b0;
    @(negedge aclk);
    chk("t5_tvalid", 32'(m_axis_tvalid), 32'(0));
    chk("t5_busy", 32'(busy), 32'(0));
    chk("t5_ovf", 32'(ovf), 32'(0));
    reset = 1'b0;
    send_frame(2, 16'h0010);
    wait_valid(lat);
    chk("t5_first", 32'(m_axis_tdata), 32'(16'h0011));
    wait_idle();
    chk("t5_left", 32'(exp_q.size()), 32'(0));
    chk("t5_count", 32'(out_cnt), 32'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
